// File: rtl/wb_pkg.sv
// Shared widths, the writeback request record and a population-count helper
// for the writeback scheduler.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int IDX_W = $clog2(NREG);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

    function automatic logic [IDX_W:0] popcount(input logic [NREG-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, a single flop
// remembering which side must win the next two-way contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when req[1] owns the next contention; only contentions move it.
    logic prio1;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio1 ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio1 <= 1'b0;
        end else if (req == 2'b11) begin
            prio1 <= gnt[0];
        end
    end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates two writeback requesters onto one register
// file write port and tracks pending destination registers for issue hazards.
module wb_sched #(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int NREG = wb_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            issue_en,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    output logic            issue_stall,
    output logic [5:0]      pend_cnt
);

    import wb_pkg::*;

    // Handshake: a transfer happens on a cycle where valid && ready; the
    // requester holds valid/rd/data stable until then, ready never depends on
    // anything but the valids, arbiter state and rst.
    logic [1:0] gnt;
    wb_req_t    win;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_next;
    logic            issue_fire;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        win = '0;
        if (gnt[0]) begin
            win.valid = 1'b1;
            win.rd    = req0_rd;
            win.data  = req0_data;
        end else if (gnt[1]) begin
            win.valid = 1'b1;
            win.rd    = req1_rd;
            win.data  = req1_data;
        end
    end

    always_comb begin
        issue_stall = !rst && (pending[issue_rs1] || pending[issue_rs2] || pending[issue_rd]);
    end

    assign issue_fire = issue_en && !issue_stall && (issue_rd != 5'd0);

    // Clear is applied first so a same-cycle set of the same index wins.
    always_comb begin
        pend_next = pending;
        if (wb_en) begin
            pend_next[wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            pend_next[issue_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            wb_en    <= win.valid && (win.rd != 5'd0);
            if (win.valid) begin
                wb_rd   <= win.rd;
                wb_data <= win.data;
            end
            pending  <= pend_next;
            pend_cnt <= popcount(pend_next);
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// Scenario bench for wb_sched: directed cases plus a randomized run checked
// against a cycle-level reference model of arbitration and the scoreboard.
module tb_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_en;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic [5:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;

    wb_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .pend_cnt    (pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        issue_en = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        req0_valid = 1; req0_rd = 3; req1_valid = 1; req1_rd = 4;
        issue_en = 1; issue_rd = 5;
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_req0_ready got=%0b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rst_req1_ready got=%0b exp=0", req1_ready); end
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", issue_stall); end
        step();
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rst_wb_en got=%0b exp=0", wb_en); end
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL rst_pend_cnt got=%0d exp=0", pend_cnt); end
        checks++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin failures++; $display("FAIL rst_wb_regs got=%0d/%0h exp=0/0", wb_rd, wb_data); end
        rst = 0;
        idle_inputs();
        step();
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL rst_issue_ignored got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        step();
        req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%0b%0b exp=01", req1_ready, req0_ready); end
        step();
        req0_valid = 0;
        checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL single_wb_en got=%0b exp=1", wb_en); end
        checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL single_wb_rd got=%0d exp=5", wb_rd); end
        checks++; if (wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wb_data got=%0h exp=deadbeef", wb_data); end
        step();
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL single_idle_wb_en got=%0b exp=0", wb_en); end
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL single_nonpending got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_round_robin();
        bit exp0;
        do_reset();
        req0_valid = 1; req0_rd = 1; req0_data = 32'hA0A0_0001;
        req1_valid = 1; req1_rd = 2; req1_data = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            checks++; if (req0_ready !== exp0 || req1_ready !== !exp0) begin failures++; $display("FAIL rr_grant%0d got=%0b%0b exp=%0b%0b", i, req1_ready, req0_ready, !exp0, exp0); end
            step();
            checks++; if (wb_en !== 1'b1 || wb_rd !== (exp0 ? 5'd1 : 5'd2)) begin failures++; $display("FAIL rr_wb%0d got=%0b/%0d exp=1/%0d", i, wb_en, wb_rd, exp0 ? 1 : 2); end
            checks++; if (wb_data !== (exp0 ? 32'hA0A0_0001 : 32'hB0B0_0002)) begin failures++; $display("FAIL rr_data%0d got=%0h", i, wb_data); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_en = 1; issue_rd = 7;
        #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL sb_first_stall got=%0b exp=0", issue_stall); end
        step();
        issue_rd = 3; issue_rs1 = 7;
        #1;
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL sb_raw_stall got=%0b exp=1", issue_stall); end
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt1 got=%0d exp=1", pend_cnt); end
        step();
        issue_en = 0;
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL sb_stalled_ignored got=%0d exp=1", pend_cnt); end
        req1_valid = 1; req1_rd = 7; req1_data = 32'h0000_0777;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL sb_req1_ready got=%0b exp=1", req1_ready); end
        step();
        req1_valid = 0;
        checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd7) begin failures++; $display("FAIL sb_wb got=%0b/%0d exp=1/7", wb_en, wb_rd); end
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_hold got=%0b exp=1", issue_stall); end
        step();
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL sb_stall_drop got=%0b exp=0", issue_stall); end
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL sb_cnt0 got=%0d exp=0", pend_cnt); end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        do_reset();
        issue_en = 1; issue_rd = 4;
        step();
        issue_en = 0; issue_rd = 0; issue_rs1 = 4;
        req0_valid = 1; req0_rd = 0; req0_data = 32'h0000_1234;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%0b exp=1", req0_ready); end
        step();
        req0_valid = 0;
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rd0_wb_en got=%0b exp=0", wb_en); end
        checks++; if (pend_cnt !== 6'd1 || issue_stall !== 1'b1) begin failures++; $display("FAIL rd0_pending got=%0d/%0b exp=1/1", pend_cnt, issue_stall); end
        step();
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL rd0_pending_later got=%0d exp=1", pend_cnt); end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        do_reset();
        req0_valid = 1; req0_rd = 9; req0_data = 32'h0000_0099;
        step();
        req0_valid = 0;
        checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd9) begin failures++; $display("FAIL setwin_wb got=%0b/%0d exp=1/9", wb_en, wb_rd); end
        issue_en = 1; issue_rd = 9;
        #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL setwin_nostall got=%0b exp=0", issue_stall); end
        step();
        issue_en = 0; issue_rd = 0; issue_rs1 = 9;
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL setwin_cnt got=%0d exp=1", pend_cnt); end
        #1;
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL setwin_bit9 got=%0b exp=1", issue_stall); end
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        for (int i = 10; i < 13; i++) begin
            issue_en = 1; issue_rd = 5'(i);
            step();
        end
        issue_en = 0; issue_rd = 0;
        checks++; if (pend_cnt !== 6'd3) begin failures++; $display("FAIL rsti_cnt3 got=%0d exp=3", pend_cnt); end
        req0_valid = 1; req0_rd = 20; req0_data = 32'h20;
        req1_valid = 1; req1_rd = 21; req1_data = 32'h21;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rsti_first got=%0b exp=1", req0_ready); end
        step();
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL rsti_second got=%0b exp=1", req1_ready); end
        rst = 1; issue_rs1 = 10;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || issue_stall !== 1'b0) begin failures++; $display("FAIL rsti_during got=%0b%0b/%0b exp=00/0", req1_ready, req0_ready, issue_stall); end
        step();
        rst = 0;
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rsti_wb_en got=%0b exp=0", wb_en); end
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL rsti_cnt got=%0d exp=0", pend_cnt); end
        #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL rsti_stall got=%0b exp=0", issue_stall); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rsti_rr got=%0b%0b exp=01", req1_ready, req0_ready); end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        bit [31:0] pend_m;
        bit        rr_req1;
        bit        exp_en;
        bit [4:0]  exp_rd;
        bit [31:0] exp_data;
        bit        g0, g1, stall_m;
        do_reset();
        pend_m = 0; rr_req1 = 0; exp_en = 0; exp_rd = 0; exp_data = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1; req0_rd = 5'($urandom_range(0, 15)); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1; req1_rd = 5'($urandom_range(0, 15)); req1_data = $urandom;
            end
            issue_en  = ($urandom_range(0, 2) != 0);
            issue_rd  = 5'($urandom_range(0, 15));
            issue_rs1 = 5'($urandom_range(0, 15));
            issue_rs2 = 5'($urandom_range(0, 15));
            #1;
            g0 = req0_valid && (!req1_valid || !rr_req1);
            g1 = req1_valid && (!req0_valid || rr_req1);
            stall_m = (issue_rs1 != 0 && pend_m[issue_rs1]) || (issue_rs2 != 0 && pend_m[issue_rs2])
                   || (issue_rd != 0 && pend_m[issue_rd]);
            checks++; if (req0_ready !== g0 || req1_ready !== g1) begin failures++; $display("FAIL rand_grant cyc=%0d got=%0b%0b exp=%0b%0b", cyc, req1_ready, req0_ready, g1, g0); end
            checks++; if (issue_stall !== stall_m) begin failures++; $display("FAIL rand_stall cyc=%0d got=%0b exp=%0b", cyc, issue_stall, stall_m); end
            checks++; if (pend_cnt !== 6'($countones(pend_m))) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, pend_cnt, $countones(pend_m)); end
            checks++; if (wb_en !== exp_en) begin failures++; $display("FAIL rand_wb_en cyc=%0d got=%0b exp=%0b", cyc, wb_en, exp_en); end
            if (exp_en) begin
                checks++; if (wb_rd !== exp_rd || wb_data !== exp_data) begin failures++; $display("FAIL rand_wb cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, wb_rd, wb_data, exp_rd, exp_data); end
            end
            if (exp_en) pend_m[exp_rd] = 1'b0;
            if (issue_en && !stall_m && issue_rd != 0) pend_m[issue_rd] = 1'b1;
            if (g0) begin
                exp_en = (req0_rd != 0); exp_rd = req0_rd; exp_data = req0_data;
            end else if (g1) begin
                exp_en = (req1_rd != 0); exp_rd = req1_rd; exp_data = req1_data;
            end else begin
                exp_en = 0;
            end
            if (req0_valid && req1_valid) rr_req1 = g0;
            step();
            if (g0) req0_valid = 0;
            if (g1) req1_valid = 0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_rd_zero();
        test_set_wins();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
